// File: rtl/image_size_up.sv
// image_size_up: 2x nearest-neighbour upscaler. Buffers one half-size input line
// in a line RAM, then emits each pixel twice and the whole line twice.
// Ports:
//   clk_i, rst_i (async, active-high)
//   width_i/height_i : output frame size (LSB ignored), latched at frame start
//   tdata_i/tvalid_i/tready_o : input pixel stream (accepted only while filling)
//   tdata_o/tvalid_o/tready_i/tlast_o/tuser_o : output stream, tlast=end of line,
//                                               tuser=first beat of frame
//   frame_cnt_o : completed output frames (only with IMAGE_SIZE_UP_FRAME_CNT_EN)
// Optional feature macro: IMAGE_SIZE_UP_FRAME_CNT_EN
module image_size_up #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WIDTH  = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           width_i,
  input  logic [15:0]           height_i,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  input  logic                  tvalid_i,
  output logic                  tready_o,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o,
`ifdef IMAGE_SIZE_UP_FRAME_CNT_EN
  output logic                  tuser_o,
  output logic [15:0]           frame_cnt_o
`else
  output logic                  tuser_o
`endif
);

  typedef enum logic [1:0] {IDLE, FILL, EMIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_tready;
  logic [ADDR_WIDTH-1:0]   r_wm1, r_col, w_rd_addr;
  logic [15:0]             r_hm1, r_row;
  logic                    r_odd, r_rep, r_pf, r_done;
  logic [DATA_WIDTH-1:0]   r_ram [MAX_WIDTH];
  logic [DATA_WIDTH-1:0]   r_rd_dat;
  logic [DATA_WIDTH-1:0]   r_tdata;
  logic                    r_tvalid, r_tlast, r_tuser;

  // Odd sizes round down: the LSBs are intentionally dropped.
  logic [15:0] w_w, w_h;
  logic        w_cfg_ok, w_unused_lsb;
  assign w_w          = {1'b0, width_i[15:1]};
  assign w_h          = {1'b0, height_i[15:1]};
  assign w_unused_lsb = width_i[0] ^ height_i[0];
  assign w_cfg_ok     = (w_w != 16'd0) && (w_h != 16'd0) && (w_w <= 16'(MAX_WIDTH));

  logic w_acc, w_col_end, w_adv, w_line_done, w_frame_done, w_rd_en;
  assign w_acc        = r_tready && tvalid_i;
  assign w_col_end    = (r_col == r_wm1);
  // Output register advances one beat whenever it is empty or being drained.
  assign w_adv        = (r_state == EMIT) && r_pf && !r_done && (!r_tvalid || tready_i);
  assign w_line_done  = (r_state == EMIT) && r_done && r_tvalid && tready_i;
  assign w_frame_done = w_line_done && (r_row == r_hm1);
  // The RAM word is re-read in the same cycle its second copy is loaded, so the
  // next word is already waiting: no bubble at pixel/line/rep boundaries.
  assign w_rd_en      = (r_state == EMIT) && (!r_pf || (w_adv && r_odd));
  assign w_rd_addr    = (!r_pf || w_col_end) ? '0 : r_col + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cfg_ok) w_state_nxt = FILL;
      FILL:    if (w_acc && w_col_end) w_state_nxt = EMIT;
      EMIT:    if (w_line_done) w_state_nxt = w_frame_done ? IDLE : FILL;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_tready <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tready <= (w_state_nxt == FILL);
    end
  end

  // Line RAM: contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_acc)   r_ram[r_col] <= tdata_i;
    if (w_rd_en) r_rd_dat     <= r_ram[w_rd_addr];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wm1    <= '0;
      r_hm1    <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_odd    <= 1'b0;
      r_rep    <= 1'b0;
      r_pf     <= 1'b0;
      r_done   <= 1'b0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
    end else begin
      if (r_state == IDLE && w_cfg_ok) begin
        r_wm1 <= ADDR_WIDTH'(w_w - 16'd1);
        r_hm1 <= w_h - 16'd1;
      end
      if (w_acc) begin
        if (w_col_end) begin
          r_col  <= '0;
          r_odd  <= 1'b0;
          r_rep  <= 1'b0;
          r_pf   <= 1'b0;
          r_done <= 1'b0;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (r_state == EMIT && !r_pf) r_pf <= 1'b1;
      if (w_adv) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_rd_dat;
        r_tlast  <= r_odd && w_col_end;
        r_tuser  <= !r_odd && (r_col == '0) && !r_rep && (r_row == '0);
        if (r_odd) begin
          r_odd <= 1'b0;
          if (w_col_end) begin
            r_col <= '0;
            if (r_rep) r_done <= 1'b1;
            else       r_rep  <= 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end else begin
          r_odd <= 1'b1;
        end
      end else if (tready_i) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_tuser  <= 1'b0;
      end
      if (w_line_done) r_row <= w_frame_done ? 16'd0 : r_row + 16'd1;
    end
  end

`ifdef IMAGE_SIZE_UP_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)             r_frame_cnt <= '0;
    else if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign frame_cnt_o = r_frame_cnt;
`endif

  assign tready_o = r_tready;
  assign tdata_o  = r_tdata;
  assign tvalid_o = r_tvalid;
  assign tlast_o  = r_tlast;
  assign tuser_o  = r_tuser;

endmodule

// File: tb/tb_image_size_up.sv
module tb_image_size_up;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] width_i = 16'd8;
  logic [15:0] height_i = 16'd4;
  logic [15:0] tdata_i = 16'd0;
  logic        tvalid_i = 1'b0;
  logic        tready_o;
  logic [15:0] tdata_o;
  logic        tvalid_o;
  logic        tready_i = 1'b1;
  logic        tlast_o;
  logic        tuser_o;
`ifdef IMAGE_SIZE_UP_FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  image_size_up #(.DATA_WIDTH(16), .MAX_WIDTH(1024), .ADDR_WIDTH(10)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .width_i(width_i), .height_i(height_i),
    .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tready_o(tready_o),
    .tdata_o(tdata_o), .tvalid_o(tvalid_o), .tready_i(tready_i),
    .tlast_o(tlast_o),
`ifdef IMAGE_SIZE_UP_FRAME_CNT_EN
    .tuser_o(tuser_o), .frame_cnt_o(frame_cnt_o)
`else
    .tuser_o(tuser_o)
`endif
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] d;
    logic        last;
    logic        user;
    logic        eof;
  } beat_t;

  beat_t sb[$];
  beat_t e;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    exp_fc = 0;
  logic  rand_rdy = 1'b0;
  logic  prev_stall = 1'b0;
  logic [18:0] prev_out = '0;

  always @(posedge clk_i) cyc++;

  // Output-ready driver, moved well clear of both clock edges.
  initial forever begin
    @(posedge clk_i);
    #2;
    tready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard monitor: pops one expected beat per observed transfer.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall = 1'b0;
      exp_fc = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert ({tvalid_o, tdata_o, tlast_o, tuser_o} === prev_out)
        else begin errors++; $error("FAIL hold obs=%h exp=%h", {tvalid_o, tdata_o, tlast_o, tuser_o}, prev_out); end
      end
`ifdef IMAGE_SIZE_UP_FRAME_CNT_EN
      checks++;
      assert (frame_cnt_o === 16'(exp_fc))
      else begin errors++; $error("FAIL frame_cnt obs=%0d exp=%0d", frame_cnt_o, exp_fc); end
`endif
      if (tvalid_o && tready_i) begin
        checks++;
        assert (sb.size() != 0)
        else begin errors++; $error("FAIL extra_beat obs=%h exp=none", tdata_o); end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          assert ({tdata_o, tlast_o, tuser_o} === {e.d, e.last, e.user})
          else begin errors++; $error("FAIL beat obs=%h/%b/%b exp=%h/%b/%b", tdata_o, tlast_o, tuser_o, e.d, e.last, e.user); end
          if (e.eof) exp_fc++;
        end
      end
      prev_stall = tvalid_o && !tready_i;
      prev_out   = {tvalid_o, tdata_o, tlast_o, tuser_o};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin errors++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp_v); end
  endtask

  task automatic do_reset(input logic [15:0] w, input logic [15:0] h);
    @(negedge clk_i);
    rst_i = 1'b1;
    tvalid_i = 1'b0;
    width_i = w;
    height_i = h;
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic send_px(input logic [15:0] d, output int acc_cyc);
    bit ok = 1'b0;
    int n = 0;
    tdata_i = d;
    tvalid_i = 1'b1;
    while (!ok && n < 600) begin
      if (tready_o) ok = 1'b1;
      @(negedge clk_i);
      n++;
    end
    acc_cyc = cyc;
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  // Sends one input row and queues the 4W output beats it should produce.
  task automatic send_row(input int r, input int w, input int h, input int base, output int acc_cyc);
    beat_t b;
    for (int c = 0; c < w; c++) send_px(16'(base + r * w + c), acc_cyc);
    tvalid_i = 1'b0;
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 0; k < 2 * w; k++) begin
        b.d    = 16'(base + r * w + k / 2);
        b.last = (k == 2 * w - 1);
        b.user = (r == 0 && rep == 0 && k == 0);
        b.eof  = (r == h - 1 && rep == 1 && k == 2 * w - 1);
        sb.push_back(b);
      end
    end
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while ((sb.size() != 0 || tvalid_o) && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk(tag, {31'd0, (sb.size() == 0 && !tvalid_o)}, 32'd1);
  endtask

  initial begin
    int n_acc;
    int n;
    // reset state
    repeat (3) @(negedge clk_i);
    chk("rst_tvalid", 32'(tvalid_o), 32'd0);
    chk("rst_tready", 32'(tready_o), 32'd0);
    chk("rst_tlast",  32'(tlast_o),  32'd0);
    chk("rst_tuser",  32'(tuser_o),  32'd0);
    chk("rst_tdata",  32'(tdata_o),  32'd0);
    rst_i = 1'b0;

    // 8x4 frame, latency and gap-free emission of row 0
    send_row(0, 4, 2, 0, n_acc);
    chk("rdy_drop", 32'(tready_o), 32'd0);
    @(negedge clk_i);
    chk("lat_n1", 32'(tvalid_o), 32'd0);
    @(negedge clk_i);
    chk("lat_cyc", 32'(cyc - n_acc), 32'd2);
    for (int i = 0; i < 16; i++) begin
      chk("no_gap", {30'd0, tvalid_o, tready_o}, 32'b10);
      @(negedge clk_i);
    end
    chk("refill", {30'd0, tvalid_o, tready_o}, 32'b01);
    send_row(1, 4, 2, 0, n_acc);
    wait_drain(200, "drain_t1");

    // random output backpressure
    do_reset(16'd8, 16'd4);
    rand_rdy = 1'b1;
    send_row(0, 4, 2, 0, n_acc);
    send_row(1, 4, 2, 0, n_acc);
    wait_drain(600, "drain_t3");
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk_i);

    // odd sizes round down
    do_reset(16'd9, 16'd5);
    send_row(0, 4, 2, 16'h10, n_acc);
    send_row(1, 4, 2, 16'h10, n_acc);
    wait_drain(200, "drain_t4");

    // illegal widths/heights: never ready, never valid
    do_reset(16'd1, 16'd4);
    tvalid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      chk("w0_idle", {30'd0, tready_o, tvalid_o}, 32'd0);
      @(negedge clk_i);
    end
    do_reset(16'd8, 16'd1);
    tvalid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("h0_idle", {30'd0, tready_o, tvalid_o}, 32'd0);
      @(negedge clk_i);
    end
    tvalid_i = 1'b0;

    // reset during EMIT of row 1
    do_reset(16'd8, 16'd4);
    send_row(0, 4, 2, 0, n_acc);
    send_row(1, 4, 2, 0, n_acc);
    n = 0;
    while (!tvalid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("emit_r1", 32'(tvalid_o), 32'd1);
    repeat (3) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1 chk("async_rst", {30'd0, tvalid_o, tready_o}, 32'd0);
    sb.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    send_row(0, 4, 2, 0, n_acc);
    send_row(1, 4, 2, 0, n_acc);
    wait_drain(200, "drain_t5");

`ifdef IMAGE_SIZE_UP_FRAME_CNT_EN
    // two back-to-back frames: counter steps on each beat-31 transfer
    do_reset(16'd8, 16'd4);
    chk("fc_zero", 32'(frame_cnt_o), 32'd0);
    for (int f = 0; f < 2; f++) begin
      send_row(0, 4, 2, 0, n_acc);
      send_row(1, 4, 2, 0, n_acc);
    end
    wait_drain(300, "drain_t6");
    chk("fc_two", 32'(frame_cnt_o), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
